online_log_taylor_horner: RTL and testbench

Iterative, parametrised successor to the fixed two-term online-arithmetic log evaluator. It computes y = sum(k=0..N) c_k·(x−1)^k by Horner's rule, one online multiply-add per cycle. The polynomial order N is selected per job, and the coefficients sit in a runtime-writable register file. It connects to the datapath through valid/ready handshakes on input and output, and reuses the existing `online_adder` and `online_mult` cores.

---
 rtl/online_pkg.sv | 23 ++
 rtl/online_adder.sv | 48 ++++
 rtl/online_horner_step.sv | 37 +++
 rtl/online_mult.sv | 44 ++++
 rtl/online_log_taylor_horner.sv | 145 ++++++++++++++
 tb/tb_online_log_taylor_horner.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/online_pkg.sv
// Shared constants, helpers and state encoding for the online-arithmetic cores.
// Signed digits are {pos, neg} bit pairs; the MSB digit of a word carries weight 2^0.
package online_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int wl(input int stage);
        return DIGIT_W * stage;
    endfunction

    // Digit 2'b01 (value -1) in the most significant position, zeros elsewhere.
    function automatic logic [63:0] minus_one(input int stage);
        return 64'(1) << (wl(stage) - 2);
    endfunction

endpackage

// File: rtl/online_adder.sv
// Signed-digit adder: a + b + cin, full-precision result one digit wider than the operands.
// The result is emitted sign-magnitude style, so dropping low digits truncates toward zero.
module online_adder
    import online_pkg::*;
#(
    parameter int STAGE = 8
) (
    input  logic [2*STAGE-1:0] a,
    input  logic [2*STAGE-1:0] b,
    input  logic               cin,
    output logic [2*STAGE+1:0] s
);
    localparam int WL = wl(STAGE);
    localparam int SW = STAGE + 2;
    localparam int MW = STAGE + 1;

    logic [STAGE-1:0]     a_pos, a_neg, b_pos, b_neg;
    logic signed [SW-1:0] sum;
    logic [MW-1:0]        mag;
    logic                 sum_neg;
    logic [WL-1:0]        unused_a_chk;

    genvar gi;
    generate
        for (gi = 0; gi < STAGE; gi++) begin : g_split
            assign a_pos[gi] = a[2*gi+1];
            assign a_neg[gi] = a[2*gi];
            assign b_pos[gi] = b[2*gi+1];
            assign b_neg[gi] = b[2*gi];
        end
    endgenerate

    assign unused_a_chk = a;

    assign sum = $signed({2'b00, a_pos}) - $signed({2'b00, a_neg})
               + $signed({2'b00, b_pos}) - $signed({2'b00, b_neg})
               + $signed({{(SW-1){1'b0}}, cin});
    assign sum_neg = sum[SW-1];
    assign mag     = sum_neg ? MW'(-sum) : MW'(sum);

    generate
        for (gi = 0; gi < MW; gi++) begin : g_pack
            assign s[2*gi+1] = mag[gi] & ~sum_neg;
            assign s[2*gi]   = mag[gi] & sum_neg;
        end
    endgenerate

endmodule

// File: rtl/online_horner_step.sv
// One Horner step: acc_next = top(top(acc * t) + c), keeping the most significant word each time.
module online_horner_step
    import online_pkg::*;
#(
    parameter int STAGE = 8
) (
    input  logic [2*STAGE-1:0] acc,
    input  logic [2*STAGE-1:0] t,
    input  logic [2*STAGE-1:0] c,
    output logic [2*STAGE-1:0] acc_next
);
    localparam int WL = wl(STAGE);

    logic [2*WL-1:0] prod_full;
    logic [WL-1:0]   p;
    logic [WL+1:0]   sum_full;
    logic [WL+1:0]   unused_low_bits;

    online_mult #(.STAGE(STAGE)) u_mult (
        .a (acc),
        .b (t),
        .p (prod_full)
    );

    assign p = prod_full[2*WL-1:WL];

    online_adder #(.STAGE(STAGE)) u_add (
        .a   (p),
        .b   (c),
        .cin (1'b0),
        .s   (sum_full)
    );

    assign acc_next        = sum_full[WL+1:2];
    assign unused_low_bits = {prod_full[WL-1:2], sum_full[1:0]};

endmodule

// File: rtl/online_mult.sv
// Signed-digit multiplier: a * b at full precision (2*STAGE digits).
// Output digits are sign-magnitude style, so keeping the upper half truncates toward zero.
module online_mult
    import online_pkg::*;
#(
    parameter int STAGE = 8
) (
    input  logic [2*STAGE-1:0] a,
    input  logic [2*STAGE-1:0] b,
    output logic [4*STAGE-1:0] p
);
    localparam int PW = 2 * STAGE + 2;
    localparam int MW = 2 * STAGE;

    logic [STAGE-1:0]        a_pos, a_neg, b_pos, b_neg;
    logic signed [STAGE:0]   ia, ib;
    logic signed [PW-1:0]    prod;
    logic [MW-1:0]           mag;
    logic                    prod_neg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGE; gi++) begin : g_split
            assign a_pos[gi] = a[2*gi+1];
            assign a_neg[gi] = a[2*gi];
            assign b_pos[gi] = b[2*gi+1];
            assign b_neg[gi] = b[2*gi];
        end
    endgenerate

    assign ia       = $signed({1'b0, a_pos}) - $signed({1'b0, a_neg});
    assign ib       = $signed({1'b0, b_pos}) - $signed({1'b0, b_neg});
    assign prod     = PW'(ia) * PW'(ib);
    assign prod_neg = prod[PW-1];
    assign mag      = prod_neg ? MW'(-prod) : MW'(prod);

    generate
        for (gi = 0; gi < MW; gi++) begin : g_pack
            assign p[2*gi+1] = mag[gi] & ~prod_neg;
            assign p[2*gi]   = mag[gi] & prod_neg;
        end
    endgenerate

endmodule

// File: rtl/online_log_taylor_horner.sv
// Iterative Horner evaluator of y = sum c_k (x-1)^k with a runtime-writable coefficient file.
// One multiply-add per ITER cycle; result held in DONE until out_ready.
module online_log_taylor_horner
    import online_pkg::*;
#(
    parameter int STAGE     = 8,
    parameter int ORDER_MAX = 4,
    parameter logic [(ORDER_MAX+1)*2*STAGE-1:0] COEF_INIT =
        {16'h0000, 16'h0000, 16'h02a0, 16'h0a2a, 16'h0000}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2*STAGE-1:0]                 in_x,
    input  logic [$clog2(ORDER_MAX+1)-1:0]     in_order,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [2*STAGE-1:0]                 out_y,
    input  logic                               coef_we,
    input  logic [$clog2(ORDER_MAX+1)-1:0]     coef_addr,
    input  logic [2*STAGE-1:0]                 coef_wdata,
    output logic                               coef_ready,
    output logic                               busy
);
    localparam int WL = wl(STAGE);
    localparam int AW = $clog2(ORDER_MAX + 1);
    localparam logic [WL-1:0] M1    = WL'(minus_one(STAGE));
    localparam logic [AW-1:0] N_MAX = AW'(ORDER_MAX);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_ITER = ITER;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state_reg;
    logic [WL-1:0] x_reg, t_reg, acc_reg, out_y_reg;
    logic          out_valid_reg;
    logic [AW-1:0] n_reg, k_reg;

    logic [ORDER_MAX:0][WL-1:0] coef_vec;
    logic          idle_ok, accept, coef_wr;
    logic [AW-1:0] n_clamped, k_dec;
    logic [WL+1:0] t_full;
    logic [WL-1:0] t_next, acc_next;
    logic [1:0]    unused_t_bits;

    assign idle_ok    = (state_reg == ST_IDLE) && !rst;
    assign in_ready   = idle_ok;
    assign coef_ready = idle_ok;
    assign busy       = (state_reg != ST_IDLE);
    assign out_valid  = out_valid_reg;
    assign out_y      = out_y_reg;

    assign accept    = in_valid && idle_ok;
    assign coef_wr   = coef_we && idle_ok && (coef_addr <= N_MAX);
    assign n_clamped = (in_order > N_MAX) ? N_MAX : in_order;
    assign k_dec     = k_reg - AW'(1);

    // Coefficient file: plain registers so reset can restore COEF_INIT.
    genvar gi;
    generate
        for (gi = 0; gi <= ORDER_MAX; gi++) begin : g_coef
            logic [WL-1:0] c_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    c_reg <= COEF_INIT[gi*WL +: WL];
                end else if (coef_wr && (coef_addr == AW'(gi))) begin
                    c_reg <= coef_wdata;
                end
            end
            assign coef_vec[gi] = c_reg;
        end
    endgenerate

    online_adder #(.STAGE(STAGE)) u_shift (
        .a   (x_reg),
        .b   (M1),
        .cin (1'b0),
        .s   (t_full)
    );

    assign t_next        = t_full[WL+1:2];
    assign unused_t_bits = t_full[1:0];

    online_horner_step #(.STAGE(STAGE)) u_step (
        .acc      (acc_reg),
        .t        (t_reg),
        .c        (coef_vec[k_dec]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            t_reg         <= '0;
            acc_reg       <= '0;
            out_y_reg     <= '0;
            out_valid_reg <= 1'b0;
            n_reg         <= '0;
            k_reg         <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        x_reg     <= in_x;
                        n_reg     <= n_clamped;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    t_reg   <= t_next;
                    acc_reg <= coef_vec[n_reg];
                    k_reg   <= n_reg;
                    if (n_reg == '0) begin
                        out_y_reg     <= coef_vec[n_reg];
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        state_reg <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_dec;
                    // k == 1 means this step consumed c0: the result is final.
                    if (k_reg == AW'(1)) begin
                        out_y_reg     <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_online_log_taylor_horner.sv
// Directed bench for online_log_taylor_horner: value-level reference model of the digit
// arithmetic, shadow coefficient file, per-scenario tasks with inline comparisons.
module tb_online_log_taylor_horner;
    localparam int STAGE     = 8;
    localparam int ORDER_MAX = 4;
    localparam int WL        = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_x;
    logic [2:0]    in_order;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_y;
    logic          coef_we;
    logic [2:0]    coef_addr;
    logic [WL-1:0] coef_wdata;
    logic          coef_ready;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WL-1:0] shadow [0:ORDER_MAX];

    always #5 clk = ~clk;

    online_log_taylor_horner #(.STAGE(STAGE), .ORDER_MAX(ORDER_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_order   (in_order),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_ready (coef_ready),
        .busy       (busy)
    );

    // Word value in units of 2^-(STAGE-1): MSB digit weighs 2^(STAGE-1).
    function automatic int sd2int(input logic [WL-1:0] w);
        int v;
        logic [1:0] d;
        v = 0;
        for (int i = WL/2 - 1; i >= 0; i--) begin
            d = w[2*i +: 2];
            v = v * 2 + ((d == 2'b10) ? 1 : ((d == 2'b01) ? -1 : 0));
        end
        return v;
    endfunction

    function automatic logic [WL-1:0] int2sd(input int v);
        logic [WL-1:0] w;
        int m;
        w = '0;
        m = (v < 0) ? -v : v;
        for (int i = 0; i < WL/2; i++) begin
            if (m[i]) w[2*i +: 2] = (v < 0) ? 2'b01 : 2'b10;
        end
        return w;
    endfunction

    // Keeping the top word halves an adder result and divides a product by 2^STAGE,
    // both truncating toward zero.
    function automatic logic [WL-1:0] golden(input logic [WL-1:0] x, input int n);
        int t, acc, p;
        logic [WL-1:0] m1;
        m1 = 16'h4000;
        if (n == 0) return shadow[0];
        t   = (sd2int(x) + sd2int(m1)) / 2;
        acc = sd2int(shadow[n]);
        for (int k = n; k >= 1; k--) begin
            p   = (acc * t) / 256;
            acc = (p + sd2int(shadow[k-1])) / 2;
        end
        return int2sd(acc);
    endfunction

    task automatic restore_shadow;
        shadow[0] = 16'h0000;
        shadow[1] = 16'h0a2a;
        shadow[2] = 16'h02a0;
        shadow[3] = 16'h0000;
        shadow[4] = 16'h0000;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [WL-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (a <= 3'(ORDER_MAX)) shadow[a] = d;
        $display("[TB] coef write addr=%0d data=%h", a, d);
    endtask

    // Issues one job, measures cycles from accept to out_valid, then accepts the result.
    task automatic run_job(input logic [WL-1:0] x, input logic [2:0] ord,
                           output logic [WL-1:0] y, output int lat);
        in_x = x; in_order = ord; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        y = out_y;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] job x=%h order=%0d y=%h latency=%0d", x, ord, y, lat);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_held got %b exp 0", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        n_tests++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL rst_coef_ready got %b exp 1", coef_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_tests++; if (out_y !== 16'h0000) begin n_fail++; $display("FAIL rst_out_y got %h exp 0000", out_y); end
        @(posedge clk); #1;
        $display("[TB] reset released");
    endtask

    task automatic test_default_n2;
        logic [WL-1:0] x, y, exp_y;
        int lat;
        for (int i = 0; i < 102; i++) begin
            x = (i == 0) ? 16'h4000 : ((i == 1) ? 16'h0000 : 16'($urandom));
            exp_y = golden(x, 2);
            run_job(x, 3'd2, y, lat);
            n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL n2_out_y x=%h got %h exp %h", x, y, exp_y); end
            n_tests++; if (lat != 4) begin n_fail++; $display("FAIL n2_latency x=%h got %0d exp 4", x, lat); end
        end
    endtask

    task automatic test_zero_coefs;
        logic [WL-1:0] x, y;
        int lat;
        for (int k = 0; k <= ORDER_MAX; k++) write_coef(3'(k), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            run_job(x, 3'd4, y, lat);
            n_tests++; if (y !== 16'h0000) begin n_fail++; $display("FAIL zero_out_y x=%h got %h exp 0000", x, y); end
            n_tests++; if (lat != 6) begin n_fail++; $display("FAIL zero_latency x=%h got %0d exp 6", x, lat); end
        end
    endtask

    task automatic test_order0_clamp;
        logic [WL-1:0] x, y, exp_y;
        int lat;
        write_coef(3'd0, 16'h0a2a);
        x = 16'($urandom);
        run_job(x, 3'd0, y, lat);
        n_tests++; if (y !== 16'h0a2a) begin n_fail++; $display("FAIL n0_out_y got %h exp 0a2a", y); end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL n0_latency got %0d exp 2", lat); end
        write_coef(3'd3, 16'h0a2a);
        write_coef(3'd4, 16'h02a0);
        x = 16'h4000;
        exp_y = golden(x, 4);
        run_job(x, 3'd7, y, lat);
        n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL clamp_out_y got %h exp %h", y, exp_y); end
        n_tests++; if (lat != 6) begin n_fail++; $display("FAIL clamp_latency got %0d exp 6", lat); end
    endtask

    task automatic test_stall;
        logic [WL-1:0] x, y, exp_y;
        int lat;
        x = 16'h9a65;
        exp_y = golden(x, 1);
        in_x = x; in_order = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL stall_latency got %0d exp 3", lat); end
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid c%0d got %b exp 1", i, out_valid); end
            n_tests++; if (out_y !== exp_y) begin n_fail++; $display("FAIL stall_out_y c%0d got %h exp %h", i, out_y, exp_y); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d got %b exp 0", i, in_ready); end
            n_tests++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL stall_coef_ready c%0d got %b exp 0", i, coef_ready); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy c%0d got %b exp 1", i, busy); end
            if (i == 3) begin
                coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h2aaa;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] stall job x=%h y=%h released after 10 cycles", x, exp_y);
        run_job(16'h0000, 3'd0, y, lat);
        n_tests++; if (y !== shadow[0]) begin n_fail++; $display("FAIL stall_write_dropped got %h exp %h", y, shadow[0]); end
    endtask

    task automatic test_reset_mid_job;
        logic [WL-1:0] y, exp_y;
        int lat;
        bit seen;
        in_x = 16'h4000; in_order = 3'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        n_tests++; if (out_y !== 16'h0000) begin n_fail++; $display("FAIL midrst_out_y got %h exp 0000", out_y); end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL midrst_aborted got out_valid exp none"); end
        $display("[TB] reset during ITER k=2, job aborted");
        restore_shadow();
        exp_y = golden(16'h4000, 2);
        run_job(16'h4000, 3'd2, y, lat);
        n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL midrst_next_y got %h exp %h", y, exp_y); end
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL midrst_next_latency got %0d exp 4", lat); end
    endtask

    task automatic test_same_cycle;
        logic [WL-1:0] y, exp_y;
        int lat;
        coef_we = 1'b1; coef_addr = 3'd1; coef_wdata = 16'h0000;
        in_x = 16'h4000; in_order = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0; in_valid = 1'b0;
        shadow[1] = 16'h0000;
        exp_y = golden(16'h4000, 1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        y = out_y;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] same-cycle write+job y=%h latency=%0d", y, lat);
        n_tests++; if (y !== exp_y) begin n_fail++; $display("FAIL same_cycle_y got %h exp %h", y, exp_y); end
        n_tests++; if (y !== 16'h0000) begin n_fail++; $display("FAIL same_cycle_y_c0 got %h exp 0000", y); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL same_cycle_latency got %0d exp 3", lat); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_order = '0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        restore_shadow();
        test_reset();
        test_default_n2();
        test_zero_coefs();
        test_order0_clamp();
        test_stall();
        test_reset_mid_job();
        test_same_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
